// File: rtl/frame_stream_reader.sv
// Raster-order frame-buffer reader: issues pixel reads with optional mirror/flip,
// realigns read data through a credit-managed FIFO and emits an Avalon-ST stream.
module frame_stream_reader #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic              mirror,
    input  logic              flip,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [DATA_W-1:0] rddata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              frame_done,
    output logic [15:0]       frame_count
);

    localparam int unsigned DEPTH = RD_LAT + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_mirror_l;
    logic              r_flip_l;
    logic [RD_LAT-1:0] r_tag_v;
    logic [RD_LAT-1:0] r_tag_sop;
    logic [RD_LAT-1:0] r_tag_eop;
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [DEPTH-1:0]  r_fifo_sop;
    logic [DEPTH-1:0]  r_fifo_eop;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_frame_count;

    logic              w_at_start;
    logic              w_at_end;
    logic              w_mirror;
    logic              w_flip;
    logic [COL_W-1:0]  w_c;
    logic [ROW_W-1:0]  w_r;
    logic [ADDR_W-1:0] w_addr;
    logic [CNT_W-1:0]  w_inflight;
    logic [SUM_W-1:0]  w_used;
    logic              w_credit;
    logic              w_rden;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The first pixel of a frame uses the live mode inputs; the rest use the latched mode.
    assign w_at_start = (r_col == '0) && (r_row == '0);
    assign w_at_end   = (r_col == COL_W'(WIDTH - 1)) && (r_row == ROW_W'(HEIGHT - 1));
    assign w_mirror   = w_at_start ? mirror : r_mirror_l;
    assign w_flip     = w_at_start ? flip   : r_flip_l;
    assign w_c        = w_mirror ? (COL_W'(WIDTH - 1) - r_col) : r_col;
    assign w_r        = w_flip   ? (ROW_W'(HEIGHT - 1) - r_row) : r_row;
    assign w_addr     = ADDR_W'(w_r) * ADDR_W'(WIDTH) + ADDR_W'(w_c);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_tag_v[i]);
        end
    end

    // Credit counts the slot freed by a same-cycle pop so a full pipe streams at one pixel/cycle.
    assign w_used   = SUM_W'(r_count) + SUM_W'(w_inflight);
    assign w_credit = w_used < (SUM_W'(DEPTH) + SUM_W'(w_pop));
    assign w_rden   = reset_n & enable & ~restart & w_credit;
    assign w_push   = r_tag_v[RD_LAT-1] & ~restart;
    assign w_pop    = out_valid & out_ready;

    assign rden        = w_rden;
    assign rdaddress   = w_rden ? w_addr : '0;
    assign out_valid   = (r_count != '0);
    assign out_data    = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_sop     = out_valid & r_fifo_sop[r_rd_ptr];
    assign out_eop     = out_valid & r_fifo_eop[r_rd_ptr];
    assign frame_done  = w_pop & out_eop;
    assign frame_count = r_frame_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_mirror_l    <= 1'b0;
            r_flip_l      <= 1'b0;
            r_tag_v       <= '0;
            r_tag_sop     <= '0;
            r_tag_eop     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_frame_count <= '0;
        end else begin
            if (frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            r_tag_sop <= RD_LAT'({r_tag_sop, w_at_start});
            r_tag_eop <= RD_LAT'({r_tag_eop, w_at_end});
            if (restart) begin
                r_col    <= '0;
                r_row    <= '0;
                r_tag_v  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_tag_v <= RD_LAT'({r_tag_v, w_rden});
                if (w_rden) begin
                    if (w_at_start) begin
                        r_mirror_l <= mirror;
                        r_flip_l   <= flip;
                    end
                    if (r_col == COL_W'(WIDTH - 1)) begin
                        r_col <= '0;
                        r_row <= (r_row == ROW_W'(HEIGHT - 1)) ? '0 : r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= rddata;
            r_fifo_sop[r_wr_ptr]  <= r_tag_sop[RD_LAT-1];
            r_fifo_eop[r_wr_ptr]  <= r_tag_eop[RD_LAT-1];
        end
    end

endmodule
